// File: rtl/bias_pingpong_buf.sv
// bias_pingpong_buf: double-buffered bias store; the shadow bank fills serially
// while the active bank returns NUM_CH sign-extended biases per registered read.
module bias_pingpong_buf #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [IN_W-1:0]             wr_data,
    input  logic                        wr_last,
    input  logic                        swap,
    output logic                        swap_err,
    input  logic                        rd_en,
    input  logic [$clog2(DEPTH)-1:0]    rd_grp,
    output logic [NUM_CH*OUT_W-1:0]     bias_out,
    output logic                        bias_vld,
    output logic                        rd_err,
    output logic [$clog2(DEPTH):0]      act_groups
);
    localparam int TOT = DEPTH * NUM_CH;
    localparam int AW  = $clog2(TOT);
    localparam int GW  = $clog2(DEPTH) + 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t                  state_q, state_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    act_q;
    logic [AW:0]             act_words_q;
    logic [GW-1:0]           act_groups_q;
    logic [GW-1:0]           sh_groups;
    logic [NUM_CH*OUT_W-1:0] bias_q, bias_d;
    logic                    bias_vld_q, rd_err_q, swap_err_q;
    logic                    wr_acc, swap_acc, in_rng;
    logic [AW-1:0]           idx [NUM_CH];
    logic [IN_W-1:0]         mem_q [2][TOT];

    assign wr_ready   = (state_q == FILL);
    assign wr_acc     = wr_valid && wr_ready;
    assign swap_acc   = swap && (state_q == FULL);
    assign sh_groups  = GW'((cnt_q + (AW+1)'(NUM_CH-1)) / (AW+1)'(NUM_CH));
    assign in_rng     = GW'(rd_grp) < act_groups_q;
    assign bias_out   = bias_q;
    assign bias_vld   = bias_vld_q;
    assign rd_err     = rd_err_q;
    assign swap_err   = swap_err_q;
    assign act_groups = act_groups_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (swap_acc) begin
            state_d = FILL;
            cnt_d   = '0;
        end else if (wr_acc) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == (AW+1)'(TOT-1) || wr_last) state_d = FULL;
        end
    end

    // Words past the active bank's fill count read as zero, so a partial fill
    // never exposes stale data left from an earlier tile.
    always_comb begin
        bias_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx[k] = AW'(rd_grp) * AW'(NUM_CH) + AW'(k);
            bias_d[k*OUT_W +: OUT_W] = (in_rng && {1'b0, idx[k]} < act_words_q)
                ? OUT_W'($signed(mem_q[act_q][idx[k]])) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[!act_q][cnt_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            act_q        <= 1'b0;
            act_words_q  <= '0;
            act_groups_q <= '0;
            bias_q       <= '0;
            bias_vld_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            swap_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            swap_err_q <= swap && !swap_acc;
            bias_vld_q <= rd_en;
            rd_err_q   <= rd_en && !in_rng;
            if (rd_en) bias_q <= bias_d;
            if (swap_acc) begin
                act_q        <= !act_q;
                act_words_q  <= cnt_q;
                act_groups_q <= sh_groups;
            end
        end
    end
endmodule

// File: tb/tb_bias_pingpong_buf.sv
// tb_bias_pingpong_buf: directed bench; expected reads queued by stimulus,
// checked by an independent monitor whenever bias_vld is seen.
module tb_bias_pingpong_buf;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         wr_valid, wr_ready, wr_last, swap, swap_err, rd_en, bias_vld, rd_err;
    logic [31:0]  wr_data;
    logic [3:0]   rd_grp;
    logic [127:0] bias_out;
    logic [4:0]   act_groups;

    logic         b_wr_valid, b_wr_ready, b_wr_last, b_swap, b_swap_err, b_rd_en, b_bias_vld, b_rd_err;
    logic [15:0]  b_wr_data;
    logic [1:0]   b_rd_grp;
    logic [127:0] b_bias_out;
    logic [2:0]   b_act_groups;

    bias_pingpong_buf dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_last(wr_last), .swap(swap), .swap_err(swap_err), .rd_en(rd_en), .rd_grp(rd_grp),
        .bias_out(bias_out), .bias_vld(bias_vld), .rd_err(rd_err), .act_groups(act_groups)
    );

    bias_pingpong_buf #(.IN_W(16), .OUT_W(32), .NUM_CH(4), .DEPTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .wr_last(b_wr_last), .swap(b_swap), .swap_err(b_swap_err), .rd_en(b_rd_en), .rd_grp(b_rd_grp),
        .bias_out(b_bias_out), .bias_vld(b_bias_vld), .rd_err(b_rd_err), .act_groups(b_act_groups)
    );

    typedef struct {logic [127:0] b; logic e;} exp_t;
    exp_t q[$];
    exp_t ex;
    int errors = 0, checks = 0;

    task automatic chk(string n, logic [127:0] a, logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [127:0] p4(int a, int b, int c, int d);
        return {d, c, b, a};
    endfunction

    task automatic beat(logic [31:0] d, logic l);
        @(negedge clk);
        wr_valid = 1'b1; wr_data = d; wr_last = l;
    endtask

    task automatic idle_wr();
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic rd(logic [3:0] g, logic [127:0] e, logic err);
        @(negedge clk);
        rd_en = 1'b1; rd_grp = g;
        q.push_back('{e, err});
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_swap(logic e_err, logic [4:0] e_grp);
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        chk("swap_err", swap_err, e_err);
        chk("act_groups", act_groups, e_grp);
    endtask

    always @(negedge clk) begin
        if (rst_n && bias_vld) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected: got bias_out=%h with no pending read", bias_out);
            end else begin
                ex = q.pop_front();
                chk("sb_bias", bias_out, ex.b);
                chk("sb_rd_err", rd_err, ex.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        {wr_valid, wr_last, swap, rd_en} = '0; wr_data = '0; rd_grp = '0;
        {b_wr_valid, b_wr_last, b_swap, b_rd_en} = '0; b_wr_data = '0; b_rd_grp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(0, '0, 1'b1);
        chk("act_groups_init", act_groups, 0);
        // full bank A with k+1
        for (int k = 0; k < 64; k++) beat(k + 1, 1'b0);
        @(negedge clk);
        wr_data = 32'd999;
        chk("wr_ready_full", wr_ready, 0);
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        do_swap(1'b0, 5'd16);
        rd(3, p4(13, 14, 15, 16), 1'b0);
        rd(15, p4(61, 62, 63, 64), 1'b0);
        // fill bank B with -(k+1) while reading bank A
        fork
            begin
                for (int k = 0; k < 64; k++) beat(-(k + 1), 1'b0);
                idle_wr();
            end
            begin
                for (int i = 0; i < 16; i++) rd(i[3:0], p4(4*i+1, 4*i+2, 4*i+3, 4*i+4), 1'b0);
            end
        join
        @(negedge clk);
        swap = 1'b1; rd_en = 1'b1; rd_grp = 4'd2;
        q.push_back('{p4(9, 10, 11, 12), 1'b0});
        @(negedge clk);
        swap = 1'b0; rd_en = 1'b0;
        chk("swap_err_pp", swap_err, 0);
        chk("act_groups_pp", act_groups, 16);
        rd(0, p4(-1, -2, -3, -4), 1'b0);
        rd(15, p4(-61, -62, -63, -64), 1'b0);
        // swap attempted mid-fill, then partial fill closed by wr_last
        beat(1, 1'b0); beat(2, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0; swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        chk("swap_err_fill", swap_err, 1);
        @(negedge clk);
        chk("swap_err_pulse", swap_err, 0);
        chk("wr_ready_fill", wr_ready, 1);
        rd(1, p4(-5, -6, -7, -8), 1'b0);
        for (int k = 3; k <= 6; k++) beat(k, k == 6);
        idle_wr();
        chk("wr_ready_last", wr_ready, 0);
        do_swap(1'b0, 5'd2);
        rd(1, p4(5, 6, 0, 0), 1'b0);
        @(negedge clk);
        chk("hold_bias", bias_out, p4(5, 6, 0, 0));
        chk("hold_vld", bias_vld, 0);
        rd(2, '0, 1'b1);
        rd(0, p4(1, 2, 3, 4), 1'b0);
        // reset during fill with a read and a swap error in flight
        beat(7, 1'b0); beat(8, 1'b0); beat(9, 1'b0);
        @(negedge clk);
        wr_valid = 1'b0; swap = 1'b1; rd_en = 1'b1; rd_grp = 4'd1;
        q.push_back('{p4(5, 6, 0, 0), 1'b0});
        @(negedge clk);
        swap = 1'b0; rd_en = 1'b0;
        chk("swap_err_pre_rst", swap_err, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bias_out", bias_out, 0);
        chk("rst_bias_vld", bias_vld, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_swap_err", swap_err, 0);
        chk("rst_act_groups", act_groups, 0);
        chk("rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, '0, 1'b1);
        // 16-bit input, 32-bit lanes
        @(negedge clk);
        b_wr_valid = 1'b1; b_wr_data = 16'h8000; b_wr_last = 1'b0;
        @(negedge clk);
        b_wr_data = 16'h7FFF; b_wr_last = 1'b1;
        @(negedge clk);
        b_wr_data = 16'h1234; b_wr_last = 1'b0;
        chk("b_wr_ready_full", b_wr_ready, 0);
        @(negedge clk);
        b_wr_valid = 1'b0; b_swap = 1'b1;
        @(negedge clk);
        b_swap = 1'b0;
        chk("b_act_groups", b_act_groups, 1);
        chk("b_swap_err", b_swap_err, 0);
        b_rd_en = 1'b1; b_rd_grp = 2'd0;
        @(negedge clk);
        b_rd_en = 1'b0;
        chk("b_sext", b_bias_out, {32'h0, 32'h0, 32'h00007FFF, 32'hFFFF8000});
        chk("b_vld", b_bias_vld, 1);
        chk("b_rd_err", b_rd_err, 0);
        repeat (3) @(negedge clk);
        chk("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
